top: RTL and testbench



---
 rtl/top_pkg.sv | 91 +++++++++
 rtl/hazard_unit.sv | 40 ++++
 rtl/top.sv | 211 +++++++++++++++++++++
 tb/tb_top.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/top_pkg.sv
// Shared definitions for the five-stage MIPS pipeline: encodings, ALU control, control bundle.
package top_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned RIDX = 5;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2a;

  typedef enum logic [2:0] {
    ALU_AND = 3'd0,
    ALU_OR  = 3'd1,
    ALU_ADD = 3'd2,
    ALU_SUB = 3'd6,
    ALU_SLT = 3'd7
  } alu_op_e;

  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,
    FWD_WB   = 2'b01,
    FWD_MEM  = 2'b10
  } fwd_sel_e;

  typedef struct packed {
    logic    regwrite;
    logic    memtoreg;
    logic    memwrite;
    logic    branch;
    logic    jump;
    logic    alusrc;
    logic    regdst;
    alu_op_e alu_op;
  } ctrl_t;

  // All-zero bundle: no register write, no store, no redirect.
  localparam ctrl_t CTRL_BUBBLE = ctrl_t'('0);

  // Main decoder; anything unrecognised becomes a bubble.
  function automatic ctrl_t decode(input logic [5:0] op, input logic [5:0] funct);
    ctrl_t c;
    c = CTRL_BUBBLE;
    case (op)
      OP_RTYPE: begin
        c.regwrite = 1'b1;
        c.regdst   = 1'b1;
        case (funct)
          FN_ADD:  c.alu_op = ALU_ADD;
          FN_SUB:  c.alu_op = ALU_SUB;
          FN_AND:  c.alu_op = ALU_AND;
          FN_OR:   c.alu_op = ALU_OR;
          FN_SLT:  c.alu_op = ALU_SLT;
          default: c = CTRL_BUBBLE;
        endcase
      end
      OP_LW: begin
        c.regwrite = 1'b1;
        c.memtoreg = 1'b1;
        c.alusrc   = 1'b1;
        c.alu_op   = ALU_ADD;
      end
      OP_SW: begin
        c.memwrite = 1'b1;
        c.alusrc   = 1'b1;
        c.alu_op   = ALU_ADD;
      end
      OP_BEQ: begin
        c.branch = 1'b1;
        c.alu_op = ALU_SUB;
      end
      OP_ADDI: begin
        c.regwrite = 1'b1;
        c.alusrc   = 1'b1;
        c.alu_op   = ALU_ADD;
      end
      OP_J:    c.jump = 1'b1;
      default: c = CTRL_BUBBLE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/hazard_unit.sv
// Operand forwarding selects, load-use stall and redirect flush generation.
module hazard_unit import top_pkg::*; (
  input  logic [RIDX-1:0] id_rs,
  input  logic [RIDX-1:0] id_rt,
  input  logic [RIDX-1:0] ex_rs,
  input  logic [RIDX-1:0] ex_rt,
  input  logic            ex_memtoreg,
  input  logic            ex_redirect,
  input  logic            mem_regwrite,
  input  logic [RIDX-1:0] mem_dst,
  input  logic            wb_regwrite,
  input  logic [RIDX-1:0] wb_dst,
  output fwd_sel_e        fwd_a_c,
  output fwd_sel_e        fwd_b_c,
  output logic            stall_c,
  output logic            flush_d_c,
  output logic            flush_e_c
);

  logic load_use;

  // Newest producer wins; a taken redirect overrides the load-use stall.
  always_comb begin
    fwd_a_c  = FWD_NONE;
    fwd_b_c  = FWD_NONE;
    load_use = 1'b0;

    if (ex_rs != '0 && mem_regwrite && mem_dst == ex_rs)     fwd_a_c = FWD_MEM;
    else if (ex_rs != '0 && wb_regwrite && wb_dst == ex_rs)  fwd_a_c = FWD_WB;

    if (ex_rt != '0 && mem_regwrite && mem_dst == ex_rt)     fwd_b_c = FWD_MEM;
    else if (ex_rt != '0 && wb_regwrite && wb_dst == ex_rt)  fwd_b_c = FWD_WB;

    load_use  = ex_memtoreg && (ex_rt == id_rs || ex_rt == id_rt);
    stall_c   = load_use && !ex_redirect;
    flush_d_c = ex_redirect;
    flush_e_c = ex_redirect || load_use;
  end

endmodule

// File: rtl/top.sv
// Five-stage in-order MIPS32 subset pipeline with forwarding and EX-stage branch resolution.
module top import top_pkg::*; #(
  parameter string       IMEM_FILE = "memfile.dat",
  parameter int unsigned MEM_WORDS = 64
) (
  input  logic        clka,
  input  logic        rst,
  output logic [31:0] writedata,
  output logic [31:0] dataadr,
  output logic [31:0] dataadr_before,
  output logic        memwrite,
  output logic [31:0] instr_out
);

  localparam int unsigned AW = $clog2(MEM_WORDS);

  logic [XLEN-1:0] imem [MEM_WORDS];
  logic [XLEN-1:0] dmem [MEM_WORDS];
  logic [XLEN-1:0] rf   [32];

  // IF
  logic [XLEN-1:0] pc, pc_plus4_f, pc_next, instr_f;
  // IF/ID and ID
  logic [XLEN-1:0] ifid_instr, ifid_pc4, id_rd1, id_rd2;
  logic [RIDX-1:0] id_rs, id_rt;
  ctrl_t           id_ctrl;
  // ID/EX and EX
  ctrl_t           idex_ctrl;
  logic [XLEN-1:0] idex_rd1, idex_rd2, idex_pc4;
  logic [25:0]     idex_fields;
  logic [RIDX-1:0] ex_rs, ex_rt, ex_rd, ex_dst;
  logic [XLEN-1:0] ex_simm, ex_srca, ex_srcb_reg, ex_srcb, ex_alu, ex_target;
  logic            ex_taken;
  // EX/MEM and MEM
  logic            exmem_regwrite, exmem_memtoreg, exmem_memwrite;
  logic [XLEN-1:0] exmem_alu, exmem_wd, mem_rdata;
  logic [RIDX-1:0] exmem_dst;
  // MEM/WB and WB
  logic            memwb_regwrite, memwb_memtoreg;
  logic [XLEN-1:0] memwb_rdata, memwb_alu, wb_result;
  logic [RIDX-1:0] memwb_dst;
  // hazard control
  fwd_sel_e        fwd_a, fwd_b;
  logic            stall, flush_d, flush_e;

  assign pc_plus4_f = pc + 32'd4;
  assign instr_f    = imem[pc[AW+1:2]];
  assign instr_out  = instr_f;
  assign pc_next    = ex_taken ? ex_target : pc_plus4_f;

  // Program counter; holds on load-use stall.
  always_ff @(posedge clka or negedge rst) begin
    if (!rst)        pc <= '0;
    else if (!stall) pc <= pc_next;
  end

  // IF/ID register; flushed to a NOP on redirect.
  always_ff @(posedge clka or negedge rst) begin
    if (!rst) begin
      ifid_instr <= '0;
      ifid_pc4   <= '0;
    end else if (flush_d) begin
      ifid_instr <= '0;
      ifid_pc4   <= '0;
    end else if (!stall) begin
      ifid_instr <= instr_f;
      ifid_pc4   <= pc_plus4_f;
    end
  end

  assign id_rs   = ifid_instr[25:21];
  assign id_rt   = ifid_instr[20:16];
  assign id_ctrl = decode(ifid_instr[31:26], ifid_instr[5:0]);

  // Register read with write-through from the WB stage; $0 is hard zero.
  always_comb begin
    id_rd1 = '0;
    id_rd2 = '0;
    if (id_rs != '0) id_rd1 = (memwb_regwrite && memwb_dst == id_rs) ? wb_result : rf[id_rs];
    if (id_rt != '0) id_rd2 = (memwb_regwrite && memwb_dst == id_rt) ? wb_result : rf[id_rt];
  end

  // ID/EX register; bubble on redirect or load-use.
  always_ff @(posedge clka or negedge rst) begin
    if (!rst) begin
      idex_ctrl   <= CTRL_BUBBLE;
      idex_rd1    <= '0;
      idex_rd2    <= '0;
      idex_pc4    <= '0;
      idex_fields <= '0;
    end else if (flush_e) begin
      idex_ctrl   <= CTRL_BUBBLE;
      idex_rd1    <= '0;
      idex_rd2    <= '0;
      idex_pc4    <= '0;
      idex_fields <= '0;
    end else begin
      idex_ctrl   <= id_ctrl;
      idex_rd1    <= id_rd1;
      idex_rd2    <= id_rd2;
      idex_pc4    <= ifid_pc4;
      idex_fields <= ifid_instr[25:0];
    end
  end

  assign ex_rs   = idex_fields[25:21];
  assign ex_rt   = idex_fields[20:16];
  assign ex_rd   = idex_fields[15:11];
  assign ex_simm = {{16{idex_fields[15]}}, idex_fields[15:0]};
  assign ex_dst  = idex_ctrl.regdst ? ex_rd : ex_rt;

  // Forwarded operands and ALU.
  always_comb begin
    case (fwd_a)
      FWD_MEM: ex_srca = exmem_alu;
      FWD_WB:  ex_srca = wb_result;
      default: ex_srca = idex_rd1;
    endcase
    case (fwd_b)
      FWD_MEM: ex_srcb_reg = exmem_alu;
      FWD_WB:  ex_srcb_reg = wb_result;
      default: ex_srcb_reg = idex_rd2;
    endcase
    ex_srcb = idex_ctrl.alusrc ? ex_simm : ex_srcb_reg;
    case (idex_ctrl.alu_op)
      ALU_AND: ex_alu = ex_srca & ex_srcb;
      ALU_OR:  ex_alu = ex_srca | ex_srcb;
      ALU_ADD: ex_alu = ex_srca + ex_srcb;
      ALU_SUB: ex_alu = ex_srca - ex_srcb;
      ALU_SLT: ex_alu = {31'b0, $signed(ex_srca) < $signed(ex_srcb)};
      default: ex_alu = '0;
    endcase
  end

  assign ex_taken  = (idex_ctrl.branch && ex_alu == '0) || idex_ctrl.jump;
  assign ex_target = idex_ctrl.jump ? {idex_pc4[31:28], idex_fields, 2'b00}
                                    : idex_pc4 + {ex_simm[29:0], 2'b00};
  assign dataadr_before = ex_alu;

  hazard_unit u_hazard (
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .ex_rs        (ex_rs),
    .ex_rt        (ex_rt),
    .ex_memtoreg  (idex_ctrl.memtoreg),
    .ex_redirect  (ex_taken),
    .mem_regwrite (exmem_regwrite),
    .mem_dst      (exmem_dst),
    .wb_regwrite  (memwb_regwrite),
    .wb_dst       (memwb_dst),
    .fwd_a_c      (fwd_a),
    .fwd_b_c      (fwd_b),
    .stall_c      (stall),
    .flush_d_c    (flush_d),
    .flush_e_c    (flush_e)
  );

  // EX/MEM register.
  always_ff @(posedge clka or negedge rst) begin
    if (!rst) begin
      exmem_regwrite <= 1'b0;
      exmem_memtoreg <= 1'b0;
      exmem_memwrite <= 1'b0;
      exmem_alu      <= '0;
      exmem_wd       <= '0;
      exmem_dst      <= '0;
    end else begin
      exmem_regwrite <= idex_ctrl.regwrite;
      exmem_memtoreg <= idex_ctrl.memtoreg;
      exmem_memwrite <= idex_ctrl.memwrite;
      exmem_alu      <= ex_alu;
      exmem_wd       <= ex_srcb_reg;
      exmem_dst      <= ex_dst;
    end
  end

  assign writedata = exmem_wd;
  assign dataadr   = exmem_alu;
  assign memwrite  = exmem_memwrite;
  assign mem_rdata = dmem[exmem_alu[AW+1:2]];

  // Data memory write port.
  always_ff @(posedge clka) begin
    if (exmem_memwrite) dmem[exmem_alu[AW+1:2]] <= exmem_wd;
  end

  // MEM/WB register.
  always_ff @(posedge clka or negedge rst) begin
    if (!rst) begin
      memwb_regwrite <= 1'b0;
      memwb_memtoreg <= 1'b0;
      memwb_rdata    <= '0;
      memwb_alu      <= '0;
      memwb_dst      <= '0;
    end else begin
      memwb_regwrite <= exmem_regwrite;
      memwb_memtoreg <= exmem_memtoreg;
      memwb_rdata    <= mem_rdata;
      memwb_alu      <= exmem_alu;
      memwb_dst      <= exmem_dst;
    end
  end

  assign wb_result = memwb_memtoreg ? memwb_rdata : memwb_alu;

  // Register file write port; $0 never written.
  always_ff @(posedge clka) begin
    if (memwb_regwrite && memwb_dst != '0) rf[memwb_dst] <= wb_result;
  end

endmodule

// File: tb/tb_top.sv
// Self-checking bench for the pipeline: program table plus store scoreboard.
module tb_top;

  logic        clka;
  logic        rst;
  logic [31:0] writedata, dataadr, dataadr_before, instr_out;
  logic        memwrite;

  top #(.IMEM_FILE(""), .MEM_WORDS(64)) dut (
    .clka           (clka),
    .rst            (rst),
    .writedata      (writedata),
    .dataadr        (dataadr),
    .dataadr_before (dataadr_before),
    .memwrite       (memwrite),
    .instr_out      (instr_out)
  );

  initial clka = 1'b0;
  always #5 clka = ~clka;

  typedef struct packed {
    logic [31:0] adr;
    logic [31:0] dat;
    logic [31:0] cyc;
  } store_t;

  typedef struct {
    int unsigned base;
    int unsigned len;
    int unsigned nst;
    store_t      st0;
    store_t      st1;
    int unsigned budget;
  } vec_t;

  localparam int NVEC = 5;

  logic [31:0] rom [64];
  vec_t        vecs [NVEC];
  store_t      sb [$];
  int          n_checks;
  int          n_errors;

  function automatic vec_t mk(input int unsigned b, input int unsigned l, input int unsigned n,
                              input logic [31:0] a0, input logic [31:0] d0, input int unsigned c0,
                              input logic [31:0] a1, input logic [31:0] d1, input int unsigned c1);
    vec_t v;
    v.base = b; v.len = l; v.nst = n; v.budget = 40;
    v.st0.adr = a0; v.st0.dat = d0; v.st0.cyc = 32'(c0);
    v.st1.adr = a1; v.st1.dat = d1; v.st1.cyc = 32'(c1);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic load_prog(input int unsigned base, input int unsigned len);
    for (int i = 0; i < 64; i++) dut.imem[i] = (i < int'(len)) ? rom[base + i] : 32'h0;
  endtask

  task automatic push_stores(input vec_t v);
    sb.push_back(v.st0);
    if (v.nst > 1) sb.push_back(v.st1);
  endtask

  // Runs from reset release, matching each observed store against the scoreboard.
  task automatic run_check(input int unsigned budget);
    int unsigned cyc;
    logic [31:0] before_prev;
    store_t      e;
    cyc = 0;
    before_prev = dataadr_before;
    while (sb.size() != 0 && cyc < budget) begin
      @(posedge clka);
      cyc++;
      @(negedge clka);
      if (memwrite === 1'b1) begin
        e = sb.pop_front();
        chk("store_adr", dataadr, e.adr);
        chk("store_dat", writedata, e.dat);
        chk("store_cyc", 32'(cyc), e.cyc);
        chk("adr_before", before_prev, e.adr);
      end
      before_prev = dataadr_before;
    end
    if (sb.size() != 0) begin
      chk("store_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;

    // Harris-Harris test program
    rom[0]  = 32'h20020005; rom[1]  = 32'h2003000c; rom[2]  = 32'h2067fff7;
    rom[3]  = 32'h00e22025; rom[4]  = 32'h00642824; rom[5]  = 32'h00a42820;
    rom[6]  = 32'h10a7000a; rom[7]  = 32'h0064202a; rom[8]  = 32'h10800001;
    rom[9]  = 32'h20050000; rom[10] = 32'h00e2202a; rom[11] = 32'h00853820;
    rom[12] = 32'h00e23822; rom[13] = 32'hac670044; rom[14] = 32'h8c020050;
    rom[15] = 32'h08000011; rom[16] = 32'h20020001; rom[17] = 32'hac020054;
    // addi/add/sw: EX/MEM forwarding
    rom[18] = 32'h20020005; rom[19] = 32'h00421820; rom[20] = 32'hac030000;
    // load-use stall
    rom[21] = 32'h20060003; rom[22] = 32'hac060000; rom[23] = 32'h8c040000;
    rom[24] = 32'h00842820; rom[25] = 32'hac050004;
    // taken beq flushes two stores
    rom[26] = 32'h20010009; rom[27] = 32'h10000002; rom[28] = 32'hac010014;
    rom[29] = 32'hac010018; rom[30] = 32'hac01001c;
    // j flush, negative immediate, signed slt
    rom[31] = 32'h2001ffff; rom[32] = 32'h08000003; rom[33] = 32'hac010020;
    rom[34] = 32'hac010024; rom[35] = 32'h0020102a; rom[36] = 32'hac020028;
    for (int i = 37; i < 64; i++) rom[i] = 32'h0;

    vecs[0] = mk(0, 18, 2, 32'd80, 32'd7, 17, 32'd84, 32'd7, 22);
    vecs[1] = mk(18, 3, 1, 32'd0, 32'd10, 5, 32'd0, 32'd0, 0);
    vecs[2] = mk(21, 5, 2, 32'd0, 32'd3, 4, 32'd4, 32'd6, 8);
    vecs[3] = mk(26, 5, 1, 32'd28, 32'd9, 7, 32'd0, 32'd0, 0);
    vecs[4] = mk(31, 6, 2, 32'd36, 32'hffffffff, 7, 32'd40, 32'd1, 9);

    // Reset held ten cycles
    rst = 1'b1;
    load_prog(0, 18);
    #1 rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clka);
      chk("rst_memwrite", 32'(memwrite), 32'd0);
      chk("rst_dataadr", dataadr, 32'd0);
      chk("rst_writedata", writedata, 32'd0);
      chk("rst_instr", instr_out, 32'h20020005);
      chk("rst_adr_before", dataadr_before, 32'd0);
    end
    rst = 1'b1;
    #1 chk("fetch_pc0", instr_out, 32'h20020005);
    @(posedge clka);
    @(negedge clka);
    chk("fetch_pc4", instr_out, 32'h2003000c);

    // Program table
    for (int t = 0; t < NVEC; t++) begin
      rst = 1'b0;
      load_prog(vecs[t].base, vecs[t].len);
      repeat (2) @(negedge clka);
      rst = 1'b1;
      push_stores(vecs[t]);
      run_check(vecs[t].budget);
    end

    // Reset pulse while the first sw is in EX, then full rerun
    rst = 1'b0;
    load_prog(0, 18);
    repeat (2) @(negedge clka);
    rst = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      @(posedge clka);
      @(negedge clka);
      chk("early_memwrite", 32'(memwrite), 32'd0);
    end
    rst = 1'b0;
    #1;
    chk("pulse_memwrite", 32'(memwrite), 32'd0);
    chk("pulse_dataadr", dataadr, 32'd0);
    @(posedge clka);
    @(negedge clka);
    chk("pulse_edge_memwrite", 32'(memwrite), 32'd0);
    chk("pulse_edge_writedata", writedata, 32'd0);
    rst = 1'b1;
    push_stores(vecs[0]);
    run_check(vecs[0].budget);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global time bound
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
